rename_commit_ctrl: RTL

In-order commit controller for the renaming register file. Records each physical name as the renamer allocates it, tracks completion by tag, and retires entries strictly in allocation order. At retirement it drives the renamer's free-name port (`NAME_F`/`FE`), which returns the superseded physical register to the free list. It sits beside the renaming register file, between the rename stage (allocation) and writeback/commit (completion).

---
 rtl/rename_commit_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/rename_commit_ctrl.sv
// In-order commit controller beside the renaming register file: records allocated
// physical names, tracks completion by tag, retires in order and frees the name.
module rename_commit_ctrl #(
   parameter int unsigned name_width = 1,
   parameter int unsigned depth      = 4,
   parameter int unsigned tag_width  = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  ALLOC_E,
   input  logic [name_width-1:0] ALLOC_NAME,
   output logic                  ALLOC_READY,
   output logic [tag_width-1:0]  ALLOC_TAG,
   input  logic                  DONE_E,
   input  logic [tag_width-1:0]  DONE_TAG,
   output logic                  FREE_E,
   output logic [name_width-1:0] FREE_NAME,
   output logic [tag_width:0]    COUNT,
   output logic                  EMPTY
);

   localparam logic [tag_width:0] depth_cnt = (tag_width + 1)'(depth);

   logic [depth-1:0]      valid_q;
   logic [depth-1:0]      done_q;
   logic [name_width-1:0] name_q [depth];
   logic [tag_width-1:0]  head_q;
   logic [tag_width-1:0]  tail_q;
   logic [tag_width:0]    count_q;
   logic                  free_e_q;
   logic [name_width-1:0] free_name_q;

   logic do_alloc;
   logic do_done;
   logic do_retire;

   always_comb begin
      do_alloc  = ALLOC_E && ALLOC_READY;
      do_retire = valid_q[head_q] && done_q[head_q];
      // A completion aimed at the slot being allocated this cycle must not leak into the new entry
      do_done   = DONE_E && valid_q[DONE_TAG] && !done_q[DONE_TAG]
                  && !(do_alloc && (DONE_TAG == tail_q));
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         valid_q     <= '0;
         done_q      <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         free_e_q    <= 1'b0;
         free_name_q <= '0;
      end else begin
         if (do_retire) begin
            valid_q[head_q] <= 1'b0;
            done_q[head_q]  <= 1'b0;
            head_q          <= head_q + 1'b1;
            free_name_q     <= name_q[head_q];
         end
         free_e_q <= do_retire;
         if (do_done)
            done_q[DONE_TAG] <= 1'b1;
         if (do_alloc) begin
            valid_q[tail_q] <= 1'b1;
            done_q[tail_q]  <= 1'b0;
            tail_q          <= tail_q + 1'b1;
         end
         case ({do_alloc, do_retire})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Name storage needs no reset; valid bits guard every read
   always_ff @(posedge CLK) begin
      if (do_alloc)
         name_q[tail_q] <= ALLOC_NAME;
   end

   always_comb begin
      ALLOC_READY = count_q < depth_cnt;
      ALLOC_TAG   = tail_q;
      COUNT       = count_q;
      EMPTY       = count_q == '0;
      FREE_E      = free_e_q;
      FREE_NAME   = free_name_q;
   end

endmodule
